// File: rtl/conv_acc_tree_add.sv
// Pipelined signed adder tree feeding a group accumulator; on each group's last
// beat the sum gets bias, arithmetic rescale, optional ReLU and saturation.
module conv_acc_tree_add #(
    parameter int NUM_IN     = 6,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int SHIFT      = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [NUM_IN*DATA_WIDTH-1:0] datain,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] dataout,
    output logic                         out_valid,
    output logic                         sat_flag
);
    localparam int L  = $clog2(NUM_IN);
    localparam int TW = DATA_WIDTH + L;

    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX_A = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN_A = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0]    ACC_MAX_W = (ACC_WIDTH+1)'(ACC_MAX_A);
    localparam logic signed [ACC_WIDTH:0]    ACC_MIN_W = (ACC_WIDTH+1)'(ACC_MIN_A);
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0]    OUT_MAX_W = (ACC_WIDTH+1)'(OUT_MAX_D);
    localparam logic signed [ACC_WIDTH:0]    OUT_MIN_W = (ACC_WIDTH+1)'(OUT_MIN_D);

    logic clear;
    assign clear = !rst_n || !en;

    // Level 0 is the raw lane view; every later level grows by one bit so pair sums never overflow.
    for (genvar k = 0; k <= L; k++) begin : lvl
        localparam int CNT = (NUM_IN + (1 << k) - 1) >> k;
        logic signed [DATA_WIDTH+k-1:0] node [CNT];

        if (k == 0) begin : g_in
            for (genvar j = 0; j < CNT; j++) begin : g_lane
                assign node[j] = datain[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin : g_reg
            localparam int PCNT = (NUM_IN + (1 << (k-1)) - 1) >> (k-1);
            logic signed [DATA_WIDTH+k-1:0] pair_sum [CNT];

            for (genvar j = 0; j < CNT; j++) begin : g_pair
                if (2*j+1 < PCNT) begin : g_add
                    assign pair_sum[j] = (DATA_WIDTH+k)'(lvl[k-1].node[2*j])
                                       + (DATA_WIDTH+k)'(lvl[k-1].node[2*j+1]);
                end else begin : g_pass
                    assign pair_sum[j] = (DATA_WIDTH+k)'(lvl[k-1].node[2*j]);
                end
            end

            always_ff @(posedge clk) begin
                if (clear) begin
                    node <= '{default: '0};
                end else begin
                    node <= pair_sum;
                end
            end
        end
    end

    logic [L-1:0]                 pv;
    logic [L-1:0]                 pfirst;
    logic [L-1:0]                 plast;
    logic [L-1:0]                 prelu;
    logic signed [DATA_WIDTH-1:0] pbias [L];

    always_ff @(posedge clk) begin
        if (clear) begin
            pv     <= '0;
            pfirst <= '0;
            plast  <= '0;
            prelu  <= '0;
            pbias  <= '{default: '0};
        end else begin
            pv[0]     <= in_valid;
            pfirst[0] <= in_first;
            plast[0]  <= in_last;
            prelu[0]  <= relu_en;
            pbias[0]  <= bias;
            for (int i = 1; i < L; i++) begin
                pv[i]     <= pv[i-1];
                pfirst[i] <= pfirst[i-1];
                plast[i]  <= plast[i-1];
                prelu[i]  <= prelu[i-1];
                pbias[i]  <= pbias[i-1];
            end
        end
    end

    logic signed [TW-1:0]         tree_sum;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic signed [ACC_WIDTH:0]    acc_wide;
    logic                         grp_sat;
    logic                         grp_sat_next;
    logic                         fin_valid;
    logic signed [ACC_WIDTH-1:0]  fin_sum;
    logic signed [DATA_WIDTH-1:0] fin_bias;
    logic                         fin_relu;
    logic                         fin_sat;

    assign tree_sum = lvl[L].node[0];

    // A first beat restarts the group and its saturation history; otherwise add with clamping.
    always_comb begin
        acc_sum      = ACC_WIDTH'(tree_sum);
        acc_wide     = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(acc_sum);
        acc_next     = acc_wide[ACC_WIDTH-1:0];
        grp_sat_next = grp_sat;
        if (pfirst[L-1]) begin
            acc_next     = acc_sum;
            grp_sat_next = 1'b0;
        end else if (acc_wide > ACC_MAX_W) begin
            acc_next     = ACC_MAX_A;
            grp_sat_next = 1'b1;
        end else if (acc_wide < ACC_MIN_W) begin
            acc_next     = ACC_MIN_A;
            grp_sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            acc       <= '0;
            grp_sat   <= 1'b0;
            fin_valid <= 1'b0;
            fin_sum   <= '0;
            fin_bias  <= '0;
            fin_relu  <= 1'b0;
            fin_sat   <= 1'b0;
        end else begin
            fin_valid <= pv[L-1] && plast[L-1];
            if (pv[L-1]) begin
                acc     <= acc_next;
                grp_sat <= grp_sat_next;
                if (plast[L-1]) begin
                    fin_sum  <= acc_next;
                    fin_bias <= pbias[L-1];
                    fin_relu <= prelu[L-1];
                    fin_sat  <= grp_sat_next;
                end
            end
        end
    end

    logic signed [ACC_WIDTH:0]    res_sum;
    logic signed [ACC_WIDTH:0]    res_shift;
    logic signed [ACC_WIDTH:0]    res_relu;
    logic signed [DATA_WIDTH-1:0] res_clip;
    logic                         res_clipped;

    // One extra bit keeps accumulator-plus-bias exact before the floor shift.
    always_comb begin
        res_sum     = (ACC_WIDTH+1)'(fin_sum) + (ACC_WIDTH+1)'(fin_bias);
        res_shift   = res_sum >>> SHIFT;
        res_relu    = (fin_relu && res_shift[ACC_WIDTH]) ? '0 : res_shift;
        res_clip    = res_relu[DATA_WIDTH-1:0];
        res_clipped = 1'b0;
        if (res_relu > OUT_MAX_W) begin
            res_clip    = OUT_MAX_D;
            res_clipped = 1'b1;
        end else if (res_relu < OUT_MIN_W) begin
            res_clip    = OUT_MIN_D;
            res_clipped = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            dataout   <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= fin_valid;
            if (fin_valid) begin
                dataout  <= res_clip;
                sat_flag <= res_clipped || fin_sat;
            end else begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_acc_tree_add.sv
// Bench for conv_acc_tree_add: two DUTs (SHIFT=0 and SHIFT=2) share one stimulus
// stream; a behavioural model predicts every output cycle, directed literals pin it.
module tb_conv_acc_tree_add;
    localparam int NI  = 6;
    localparam int DW  = 16;
    localparam int AW  = 24;
    localparam int LAT = 4;
    localparam longint AMAX = (longint'(1) << (AW-1)) - 1;
    localparam longint AMIN = -AMAX - 1;
    localparam longint OMAX = (longint'(1) << (DW-1)) - 1;
    localparam longint OMIN = -OMAX - 1;

    typedef struct { int due; longint val; bit sat; } exp_t;
    typedef struct { int cyc; longint d0; bit s0; longint d2; bit s2; } obs_t;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic                 in_valid;
    logic                 in_first;
    logic                 in_last;
    logic                 relu_en;
    logic [NI*DW-1:0]     datain;
    logic signed [DW-1:0] bias;
    logic signed [DW-1:0] dout0;
    logic signed [DW-1:0] dout2;
    logic                 ov0;
    logic                 ov2;
    logic                 sat0;
    logic                 sat2;

    exp_t q0[$];
    exp_t q2[$];
    obs_t obs[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    conv_acc_tree_add #(.NUM_IN(NI), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .datain(datain), .bias(bias), .relu_en(relu_en),
        .dataout(dout0), .out_valid(ov0), .sat_flag(sat0));

    conv_acc_tree_add #(.NUM_IN(NI), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .datain(datain), .bias(bias), .relu_en(relu_en),
        .dataout(dout2), .out_valid(ov2), .sat_flag(sat2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    function automatic void chk(string name, longint got, longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    endfunction

    function automatic exp_t predict(longint acc, longint b, bit relu, bit gsat, int sh, int due);
        exp_t   e;
        longint r;
        r = (acc + b) >>> sh;
        if (relu && r < 0) r = 0;
        e.sat = gsat;
        if (r > OMAX) begin
            r = OMAX;
            e.sat = 1'b1;
        end else if (r < OMIN) begin
            r = OMIN;
            e.sat = 1'b1;
        end
        e.val = r;
        e.due = due;
        return e;
    endfunction

    function automatic logic [NI*DW-1:0] lanes_all(int v);
        logic [NI*DW-1:0] d;
        for (int i = 0; i < NI; i++) d[i*DW +: DW] = DW'(v);
        return d;
    endfunction

    function automatic logic [NI*DW-1:0] lanes_ramp(int base, int step);
        logic [NI*DW-1:0] d;
        for (int i = 0; i < NI; i++) d[i*DW +: DW] = DW'(base + step*i);
        return d;
    endfunction

    // Model: group arithmetic on whole integers, outputs due LAT edges after the capturing edge.
    initial begin : model
        longint acc_m;
        longint s;
        bit     gsat_m;
        acc_m  = 0;
        gsat_m = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n || !en) begin
                acc_m  = 0;
                gsat_m = 1'b0;
                q0.delete();
                q2.delete();
            end else if (in_valid) begin
                s = 0;
                for (int i = 0; i < NI; i++) s += longint'($signed(datain[i*DW +: DW]));
                if (in_first) begin
                    acc_m  = s;
                    gsat_m = 1'b0;
                end else begin
                    acc_m = acc_m + s;
                    if (acc_m > AMAX) begin
                        acc_m  = AMAX;
                        gsat_m = 1'b1;
                    end else if (acc_m < AMIN) begin
                        acc_m  = AMIN;
                        gsat_m = 1'b1;
                    end
                end
                if (in_last) begin
                    q0.push_back(predict(acc_m, longint'(bias), relu_en, gsat_m, 0, cyc + LAT));
                    q2.push_back(predict(acc_m, longint'(bias), relu_en, gsat_m, 2, cyc + LAT));
                end
            end
        end
    end

    initial begin : compare
        bit   e0;
        bit   e2;
        exp_t x;
        obs_t o;
        forever begin
            @(negedge clk);
            e0 = 1'b0;
            e2 = 1'b0;
            if (q0.size() > 0) e0 = (q0[0].due == cyc);
            if (q2.size() > 0) e2 = (q2[0].due == cyc);
            chk("out_valid s0", longint'(ov0), longint'(e0));
            chk("out_valid s2", longint'(ov2), longint'(e2));
            if (e0) begin
                x = q0.pop_front();
                chk("dataout s0", longint'(dout0), x.val);
                chk("sat_flag s0", longint'(sat0), longint'(x.sat));
            end else begin
                chk("sat_flag idle s0", longint'(sat0), 0);
            end
            if (e2) begin
                x = q2.pop_front();
                chk("dataout s2", longint'(dout2), x.val);
                chk("sat_flag s2", longint'(sat2), longint'(x.sat));
            end else begin
                chk("sat_flag idle s2", longint'(sat2), 0);
            end
            if (ov0 || ov2) begin
                o.cyc = cyc;
                o.d0  = longint'(dout0);
                o.s0  = sat0;
                o.d2  = longint'(dout2);
                o.s2  = sat2;
                obs.push_back(o);
            end
        end
    end

    task automatic apply_stimulus(bit v, bit f, bit l, logic [NI*DW-1:0] d, int b, bit r);
        in_valid = v;
        in_first = f;
        in_last  = l;
        datain   = d;
        bias     = DW'(b);
        relu_en  = r;
        @(negedge clk);
    endtask

    task automatic run_idle(int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_count(string name, int n);
        chk({name, " output count"}, longint'(obs.size()), longint'(n));
    endtask

    task automatic check_output(string name, int idx, longint e0, bit s0, longint e2, bit s2);
        if (idx < obs.size()) begin
            chk({name, " dataout s0"}, obs[idx].d0, e0);
            chk({name, " sat_flag s0"}, longint'(obs[idx].s0), longint'(s0));
            chk({name, " dataout s2"}, obs[idx].d2, e2);
            chk({name, " sat_flag s2"}, longint'(obs[idx].s2), longint'(s2));
        end else begin
            chk({name, " output present"}, longint'(obs.size()), longint'(idx + 1));
        end
    endtask

    task automatic clear_cycle(bit use_rst);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        if (use_rst) rst_n = 1'b0;
        else en = 1'b0;
        @(negedge clk);
        chk("clear out_valid", longint'(ov0), 0);
        chk("clear dataout s0", longint'(dout0), 0);
        chk("clear dataout s2", longint'(dout2), 0);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    initial begin : stimulus
        int t0;
        rst_n    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        relu_en  = 1'b0;
        bias     = '0;
        datain   = '0;
        repeat (3) @(negedge clk);
        chk("reset dataout", longint'(dout0), 0);
        chk("reset out_valid", longint'(ov0), 0);
        chk("reset sat_flag", longint'(sat0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        obs.delete();
        t0 = cyc;
        apply_stimulus(1, 1, 1, lanes_ramp(1, 1), 0, 0);
        run_idle(10);
        check_count("single", 1);
        check_output("single", 0, 21, 0, 5, 0);
        if (obs.size() > 0) chk("single latency", longint'(obs[0].cyc - t0), 5);

        obs.delete();
        apply_stimulus(1, 1, 0, lanes_all(100), 0, 0);
        apply_stimulus(1, 0, 0, lanes_all(200), 0, 0);
        apply_stimulus(1, 0, 1, lanes_all(-50), 10, 0);
        run_idle(10);
        check_count("three beat", 1);
        check_output("three beat", 0, 1510, 0, 377, 0);

        obs.delete();
        apply_stimulus(1, 1, 0, lanes_all(100), 0, 0);
        apply_stimulus(0, 1, 1, lanes_all(999), 77, 1);
        apply_stimulus(1, 0, 0, lanes_all(200), 0, 0);
        apply_stimulus(0, 0, 1, lanes_all(-7), 0, 0);
        apply_stimulus(0, 1, 0, lanes_all(3), 0, 0);
        apply_stimulus(1, 0, 1, lanes_all(-50), 10, 0);
        run_idle(10);
        check_count("gapped", 1);
        check_output("gapped", 0, 1510, 0, 377, 0);

        obs.delete();
        apply_stimulus(1, 1, 0, lanes_all(32767), 0, 0);
        apply_stimulus(1, 0, 1, lanes_all(32767), 0, 0);
        apply_stimulus(1, 1, 0, lanes_all(-32768), 0, 0);
        apply_stimulus(1, 0, 1, lanes_all(-32768), 0, 0);
        run_idle(10);
        check_count("clip", 2);
        check_output("clip pos", 0, 32767, 1, 32767, 1);
        check_output("clip neg", 1, -32768, 1, -32768, 1);

        obs.delete();
        apply_stimulus(1, 1, 1, lanes_ramp(-1, -1), 0, 1);
        apply_stimulus(1, 1, 1, lanes_ramp(-1, -1), 0, 0);
        run_idle(10);
        check_count("relu", 2);
        check_output("relu on", 0, 0, 0, 0, 0);
        check_output("relu off", 1, -21, 0, -6, 0);

        obs.delete();
        apply_stimulus(1, 1, 0, lanes_all(100), 0, 0);
        apply_stimulus(1, 0, 0, lanes_all(200), 0, 0);
        clear_cycle(1'b0);
        apply_stimulus(1, 1, 1, lanes_ramp(1, 1), 0, 0);
        run_idle(10);
        check_count("en clear", 1);
        check_output("en clear", 0, 21, 0, 5, 0);

        obs.delete();
        apply_stimulus(1, 1, 0, lanes_all(100), 0, 0);
        apply_stimulus(1, 0, 0, lanes_all(200), 0, 0);
        clear_cycle(1'b1);
        apply_stimulus(1, 1, 1, lanes_ramp(1, 1), 0, 0);
        run_idle(10);
        check_count("rst clear", 1);
        check_output("rst clear", 0, 21, 0, 5, 0);

        obs.delete();
        apply_stimulus(1, 1, 0, lanes_all(500), 0, 0);
        clear_cycle(1'b0);
        apply_stimulus(1, 0, 1, lanes_ramp(1, 1), 7, 0);
        run_idle(10);
        check_count("last after clear", 1);
        check_output("last after clear", 0, 28, 0, 7, 0);

        obs.delete();
        for (int k = 1; k <= 8; k++) apply_stimulus(1, 1, 1, lanes_all(k), 0, 0);
        run_idle(10);
        check_count("burst", 8);
        for (int k = 1; k <= 8; k++) check_output("burst", k - 1, 6*k, 0, (6*k) >>> 2, 0);
        if (obs.size() == 8) chk("burst spacing", longint'(obs[7].cyc - obs[0].cyc), 7);

        obs.delete();
        apply_stimulus(1, 1, 0, lanes_all(32767), 0, 0);
        for (int i = 0; i < 49; i++) apply_stimulus(1, 0, 0, lanes_all(32767), 0, 0);
        for (int i = 0; i < 42; i++) apply_stimulus(1, 0, 0, lanes_all(-32767), 0, 0);
        apply_stimulus(1, 0, 1, lanes_all(-21887), 0, 0);
        run_idle(10);
        check_count("acc sat", 1);
        check_output("acc sat", 0, 1, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_acc_tree_add.md
# conv_acc_tree_add

Parametrised, fully pipelined signed adder tree with a group accumulator for LeNet-5 convolution and FC partial sums. It reduces NUM_IN lanes per beat through a registered binary tree. It accumulates consecutive beats of one group, such as one output pixel's sum across input channels. On the group's last beat it adds a bias, rescales, applies optional ReLU and saturates to DATA_WIDTH. It sits between the multiplier array and the feature-map write-back.

## Interface
- NUM_IN, 6: lanes per beat; legal range 2..64.
- DATA_WIDTH, 16: signed lane, bias and output width.
- ACC_WIDTH, 24: signed accumulator width; must be at least DATA_WIDTH+clog2(NUM_IN).
- SHIFT, 0: arithmetic right shift applied to the final sum before saturation; legal range 0..ACC_WIDTH-2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  pipeline enable; low = synchronous clear of the datapath (see Operation).
- in_valid  in  1  beat present on datain.
- in_first  in  1  beat opens a group; qualified by in_valid.
- in_last  in  1  beat closes a group; qualified by in_valid.
- datain  in  NUM_IN*DATA_WIDTH  signed lanes; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- bias  in  DATA_WIDTH  signed bias; sampled with the in_last beat.
- relu_en  in  1  ReLU mode; sampled with the in_last beat.
- dataout  out  DATA_WIDTH  signed result; registered.
- out_valid  out  1  one-cycle pulse per completed group.
- sat_flag  out  1  result was clipped by saturation; valid with out_valid, 0 otherwise.

## Operation
- Tree: L = clog2(NUM_IN) register levels. Each level adds adjacent pairs (2k, 2k+1); an odd trailing element passes through registered, unchanged. Level k is DATA_WIDTH+k bits wide. Sign extension is used everywhere; no overflow is possible.
- Sideband registers travel with the data through every tree level: valid, first, last, bias and relu_en.
- Accumulator stage, updated on a valid beat only. In all cases below, acc_sum = tree, sign-extended to ACC_WIDTH.
  - first=1: acc <= acc_sum.
  - first=0: acc <= acc + acc_sum, saturating at ACC_WIDTH limits.
  - last=1 additionally sets the internal fin_valid, passes fin_sum = the new acc value, and carries bias and relu_en forward.
- Invalid beats leave acc unchanged and ignore the first/last flags.
- Output stage, when fin_valid:
  1. r = (fin_sum + sign-extended bias), computed at ACC_WIDTH+1 bits.
  2. r = r >>> SHIFT (truncation toward -infinity).
  3. If relu_en and r<0, r = 0.
  4. Clip r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  5. sat_flag = 1 if step 4 clipped or the accumulator saturated at any point in the group.
  6. dataout <= r; out_valid <= 1.
- When fin_valid is 0, out_valid <= 0 and dataout holds its last value.
- Group rules:
  - first and last on the same beat is a one-beat group.
  - first with a group already open discards the open partial sum silently.
  - last without a preceding first adds onto the current acc (0 after reset or clear).
- en=0 clears on every edge it is low: all pipeline valids, the accumulator, the data registers, dataout, out_valid and sat_flag go to 0. Beats in flight and the open group are lost. The tree behaves identically after en returns high.
- rst_n=0 has the same effect as en=0 and takes priority over en.

## Timing
- Reset values: dataout=0, out_valid=0, sat_flag=0, acc=0, all pipeline valids 0.
- Latency: a beat with in_last at edge n gives out_valid high after edge n+L+2. For NUM_IN=6 that is 5 cycles.
- Throughput: one beat per cycle, no stall. Back-to-back groups are legal, including last followed by first on the next cycle, with no bubble.
- No backpressure: the downstream must accept every out_valid pulse.

## Test plan
- NUM_IN=6, lanes 1..6, first=last=1, bias=0, relu_en=0 -> dataout=21, sat_flag=0, out_valid for exactly one cycle, 5 cycles after the input edge.
- Three-beat group with all lanes 100, then 200, then -50, bias=10 -> single out_valid with dataout=1510. No out_valid on the first two beats.
- Two beats with all lanes 32767 -> dataout=32767, sat_flag=1. Two beats with all lanes -32768 -> dataout=-32768, sat_flag=1.
- One beat with lanes {-1,-2,-3,-4,-5,-6}: relu_en=1 -> dataout=0, sat_flag=0; relu_en=0 -> dataout=-21. With SHIFT=2 and relu_en=0, the sum 21 gives 5 and the sum -21 gives -6.
- en dropped for one cycle mid-group (after beat 2 of 3), then a fresh one-beat group with lanes 1..6 -> output is exactly 21, no stale output appears, out_valid stays 0 during the clear. Repeat the same sequence with rst_n.
- Eight consecutive one-beat groups with lane values k (k=1..8), one per cycle -> eight consecutive out_valid cycles with dataout=6k in order. Insert invalid beats between beats of a group -> result unchanged.
